// File: rtl/addr_decoder_multi.sv
// rtl/addr_decoder_multi.sv - multi-region address decoder with per-region wait states and registered one-hot chip select
// Optional miss counter is built when ADDR_DECODER_MISS_CNT_EN is defined.
module addr_decoder_multi #(
  parameter int N_REGIONS = 4,
  parameter int ADDR_W    = 32,
  parameter int WAIT_W    = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ,
  input  logic [ADDR_W-1:0]            ADDR,
  input  logic                         CFG_WE,
  input  logic [$clog2(N_REGIONS)-1:0] CFG_IDX,
  input  logic [ADDR_W-1:0]            CFG_BASE,
  input  logic [ADDR_W-1:0]            CFG_LIMIT,
  input  logic [WAIT_W-1:0]            CFG_WAIT,
  output logic [N_REGIONS-1:0]         CS,
  output logic                         ACK,
  output logic                         ERR,
  output logic                         BUSY,
  output logic [15:0]                  MISS_CNT
);

  localparam int IDX_W = $clog2(N_REGIONS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACKS, S_ERRS} state_e;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic [N_REGIONS-1:0]   cs_q, cs_d;

  logic [ADDR_W-1:0]      base_q  [N_REGIONS];
  logic [ADDR_W-1:0]      base_d  [N_REGIONS];
  logic [ADDR_W-1:0]      limit_q [N_REGIONS];
  logic [ADDR_W-1:0]      limit_d [N_REGIONS];
  logic [WAIT_W-1:0]      wait_q  [N_REGIONS];
  logic [WAIT_W-1:0]      wait_d  [N_REGIONS];

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [WAIT_W-1:0]      hit_wait;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((base_q[i] <= ADDR) && (ADDR <= limit_q[i])) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_wait = wait_q[i];
      end
    end
  end

  // An index with no matching entry simply writes nothing.
  always_comb begin
    for (int i = 0; i < N_REGIONS; i++) begin
      base_d[i]  = base_q[i];
      limit_d[i] = limit_q[i];
      wait_d[i]  = wait_q[i];
      if (CFG_WE && (CFG_IDX == IDX_W'(i))) begin
        base_d[i]  = CFG_BASE;
        limit_d[i] = CFG_LIMIT;
        wait_d[i]  = CFG_WAIT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        wait_q[i] <= '0;
        if (i == 0) begin
          base_q[i]  <= ADDR_W'(32'h0000_4AF0);
          limit_q[i] <= ADDR_W'(32'h0000_4B0F);
        end else if (i == 1) begin
          base_q[i]  <= ADDR_W'(32'h0000_4EF0);
          limit_q[i] <= ADDR_W'(32'h0000_4F0F);
        end else begin
          base_q[i]  <= '1;
          limit_q[i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        base_q[i]  <= base_d[i];
        limit_q[i] <= limit_d[i];
        wait_q[i]  <= wait_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          if (hit) begin
            cs_d    = N_REGIONS'(1) << hit_idx;
            cnt_d   = hit_wait;
            state_d = (hit_wait != '0) ? S_WAIT : S_ACKS;
          end else begin
            state_d = S_ERRS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = S_ACKS;
        end
      end
      S_ACKS: begin
        cs_d    = '0;
        state_d = S_IDLE;
      end
      S_ERRS: begin
        state_d = S_IDLE;
      end
      default: begin
        cs_d    = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
    end
  end

  assign CS   = cs_q;
  assign ACK  = (state_q == S_ACKS);
  assign ERR  = (state_q == S_ERRS);
  assign BUSY = (state_q != S_IDLE);

`ifdef ADDR_DECODER_MISS_CNT_EN
  logic [15:0] miss_q, miss_d;

  always_comb begin
    miss_d = miss_q;
    if ((state_q == S_IDLE) && REQ && !hit && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign MISS_CNT = miss_q;
`else
  assign MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_addr_decoder_multi.sv
// tb/tb_addr_decoder_multi.sv - directed self-checking bench for addr_decoder_multi
module tb_addr_decoder_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ;
  logic [31:0] ADDR;
  logic        CFG_WE;
  logic [1:0]  CFG_IDX;
  logic [31:0] CFG_BASE;
  logic [31:0] CFG_LIMIT;
  logic [2:0]  CFG_WAIT;
  logic [3:0]  CS;
  logic        ACK;
  logic        ERR;
  logic        BUSY;
  logic [15:0] MISS_CNT;

  int checks = 0;
  int errors = 0;
  int exp_miss = 0;

  addr_decoder_multi #(.N_REGIONS(4), .ADDR_W(32), .WAIT_W(3)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR),
    .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_BASE(CFG_BASE),
    .CFG_LIMIT(CFG_LIMIT), .CFG_WAIT(CFG_WAIT),
    .CS(CS), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .MISS_CNT(MISS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_miss_cnt(input string tag);
`ifdef ADDR_DECODER_MISS_CNT_EN
    chk(tag, 32'(MISS_CNT), 32'(exp_miss));
`else
    chk(tag, 32'(MISS_CNT), 32'd0);
`endif
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] base,
                           input logic [31:0] limit, input logic [2:0] w);
    CFG_WE = 1'b1; CFG_IDX = idx; CFG_BASE = base; CFG_LIMIT = limit; CFG_WAIT = w;
    step();
    CFG_WE = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cs"},   32'(CS),   32'd0);
    chk({tag, ".busy"}, 32'(BUSY), 32'd0);
    chk({tag, ".ack"},  32'(ACK),  32'd0);
    chk({tag, ".err"},  32'(ERR),  32'd0);
  endtask

  task automatic run_hit(input logic [31:0] addr, input logic [3:0] exp_cs, input int w);
    string t;
    REQ = 1'b1; ADDR = addr;
    step();
    REQ = 1'b0;
    for (int c = 0; c <= w; c++) begin
      t = $sformatf("hit_%0h_c%0d", addr, c + 1);
      chk({t, ".cs"},   32'(CS),   32'(exp_cs));
      chk({t, ".busy"}, 32'(BUSY), 32'd1);
      chk({t, ".ack"},  32'(ACK),  32'(c == w));
      chk({t, ".err"},  32'(ERR),  32'd0);
      step();
    end
    chk_idle($sformatf("hit_%0h_done", addr));
  endtask

  task automatic chk_err_cycle(input string t);
    chk({t, ".err"},  32'(ERR),  32'd1);
    chk({t, ".cs"},   32'(CS),   32'd0);
    chk({t, ".busy"}, 32'(BUSY), 32'd1);
    chk({t, ".ack"},  32'(ACK),  32'd0);
    exp_miss++;
    step();
    chk_idle({t, "_done"});
  endtask

  task automatic run_miss(input logic [31:0] addr);
    REQ = 1'b1; ADDR = addr;
    step();
    REQ = 1'b0;
    chk_err_cycle($sformatf("miss_%0h", addr));
  endtask

  initial begin
    RST = 1'b0; REQ = 1'b0; ADDR = '0;
    CFG_WE = 1'b0; CFG_IDX = '0; CFG_BASE = '0; CFG_LIMIT = '0; CFG_WAIT = '0;
    step();
    step();
    chk_idle("reset");
    chk("reset.miss", 32'(MISS_CNT), 32'd0);
    RST = 1'b1;
    step();

    // default regions and their edges
    run_hit(32'h4AF0, 4'b0001, 0);
    run_hit(32'h4B0F, 4'b0001, 0);
    run_hit(32'h4EF0, 4'b0010, 0);
    run_hit(32'h4F0F, 4'b0010, 0);
    run_miss(32'h4AEF);
    run_miss(32'h4B10);
    chk_miss_cnt("miss_cnt_2");

    cfg_write(2'd2, 32'h1000, 32'h10FF, 3'd3);
    run_hit(32'h1080, 4'b0100, 3);
    run_hit(32'h1000, 4'b0100, 3);
    run_hit(32'h10FF, 4'b0100, 3);
    run_miss(32'h0FFF);

    // overlap: region 0 now covers part of region 1
    cfg_write(2'd0, 32'h4EF0, 32'h4EFF, 3'd0);
    run_hit(32'h4EF8, 4'b0001, 0);
    run_hit(32'h4F00, 4'b0010, 0);

    // write coinciding with a request decodes against the old table
    REQ = 1'b1; ADDR = 32'h2000;
    CFG_WE = 1'b1; CFG_IDX = 2'd3; CFG_BASE = 32'h2000; CFG_LIMIT = 32'h2FFF; CFG_WAIT = 3'd1;
    step();
    REQ = 1'b0; CFG_WE = 1'b0;
    chk_err_cycle("coincident_write");
    run_hit(32'h2000, 4'b1000, 1);
    chk_miss_cnt("miss_cnt_4");

    // table write and extra request during an in-flight wait-3 access
    REQ = 1'b1; ADDR = 32'h1080;
    step();
    chk("inflight_c1.cs", 32'(CS), 32'h4);
    CFG_WE = 1'b1; CFG_IDX = 2'd2; CFG_BASE = 32'h1000; CFG_LIMIT = 32'h10FF; CFG_WAIT = 3'd0;
    step();
    CFG_WE = 1'b0;
    chk("inflight_c2.ack", 32'(ACK), 32'd0);
    chk("inflight_c2.cs", 32'(CS), 32'h4);
    step();
    chk("inflight_c3.ack", 32'(ACK), 32'd0);
    chk("inflight_c3.busy", 32'(BUSY), 32'd1);
    step();
    REQ = 1'b0;
    chk("inflight_c4.ack", 32'(ACK), 32'd1);
    chk("inflight_c4.cs", 32'(CS), 32'h4);
    step();
    chk_idle("inflight_done");
    run_hit(32'h1080, 4'b0100, 0);

    // reset in the middle of a wait
    cfg_write(2'd2, 32'h1000, 32'h10FF, 3'd3);
    REQ = 1'b1; ADDR = 32'h1080;
    step();
    REQ = 1'b0;
    step();
    chk("prereset.busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    #1;
    chk_idle("midreset");
    exp_miss = 0;
    chk_miss_cnt("midreset.miss");
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("inreset_c%0d.ack", c), 32'(ACK), 32'd0);
    end
    RST = 1'b1;
    step();
    run_miss(32'h1080);
    run_hit(32'h4EF0, 4'b0010, 0);
    run_hit(32'h4AF0, 4'b0001, 0);
    run_miss(32'h2000);
    chk_miss_cnt("after_reset_miss");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
